dff: RTL and testbench
======================

Name: dff

Overview:
- Positive-edge D flip-flop with complementary outputs; the base storage cell for the team's sequential exercises (e.g. next-state logic registered into a single state bit).
- Adds synchronous preset and clear, and a synchronous active-low reset.
- Parameterizable width; default WIDTH=1 is the drop-in single-bit cell.

Parameters:
- WIDTH, 1, number of stored bits; applies to d, q and qnot.
- RESET_VAL, 0 (all bits), value loaded while rst_n is low.

Ports:
- clk      input   1      single clock; every state change on the rising edge.
- rst_n    input   1      synchronous active-low reset; sampled on clk rising edge.
- q        output  WIDTH  stored value.
- qnot     output  WIDTH  bitwise complement of q.
- d        input   WIDTH  data captured on clk rising edge.
- preset   input   1      synchronous active-high set; tie 0 when unused.
- clear    input   1      synchronous active-high clear; tie 0 when unused.

Interface note: one clock (clk); reset is synchronous and active-low (rst_n). Positional order after clk/rst_n is q, qnot, d, preset, clear.

Behaviour:
- All updates occur only on clk rising edge. There is no asynchronous path.
- Priority at each rising edge, highest first:
  - rst_n==0: q <= RESET_VAL.
  - clear==1: q <= all zeros. Clear wins over preset when both are high.
  - preset==1: q <= all ones.
  - otherwise: q <= d.
- qnot is purely combinational: always exactly ~q, with no extra latency. When q is X, qnot is X.
- Latency: d sampled at edge N appears on q immediately after edge N (one-cycle register). Changes on d between edges have no effect.
- Power-up: q is undefined (X in simulation) until the first rising edge that has rst_n low, or that captures a defined d/preset/clear.
- Reset deasserted mid-run: the first edge with rst_n==1 resumes normal priority. There is no additional recovery cycle.
- Reset release has no requirement relative to d; d is simply sampled at the next edge.
- Inputs change away from the rising edge (bench drives on even multiples of the half-period). No setup/hold modelling is required.

Optional Feature:
- DFF_CE_EN:
  - Defined: adds input port ce (1 bit, after clear).
  - When ce==0 at a rising edge, the preset, clear and d branches hold q unchanged.
  - rst_n still takes effect regardless of ce.
  - When ce==1, behaviour is identical to the base block.
- Undefined: no ce port; the block behaves as if ce is permanently 1.

Decomposition:
- Shared package dff_pkg holds:
  - default WIDTH;
  - RESET_VAL default;
  - the priority-encoding localparams (SEL_RST, SEL_CLR, SEL_SET, SEL_D) used for next-state select, so variants share one definition.
- Sub-module dff_next (combinational next-state mux: rst_n/clear/preset/ce/d -> next value) is natural.
- The top then holds only the clocked register and the qnot assign.

Test Plan:
1. Reset: rst_n=0 across one edge with d=1, preset=0, clear=0 -> q=0, qnot=1. Then release rst_n with d=1 -> q=1 after the next edge.
2. Capture/latency: clk period 10, preset=clear=0, d pattern 0,1,0,1 changed at t=10,20,30,40 -> q follows d after each edge. q never changes between edges.
3. Controls: preset=1, d=0 -> q=1. Then clear=1, preset=1 together -> q=0. Then clear=0, preset=0, d=1 -> q=1. Finally rst_n=0 with clear=0, preset=1 -> q=0 (reset dominates).
4. Registered logic: drive d = (~a&b&c&d_in)|(a&~c&d_in)|(a&~b&c)|(a&c&~d_in) over all 16 minterms, one per 10 time units:
   - minterm 7 -> q=1 after the edge;
   - minterms 0–6 -> q=0;
   - minterms 8, 12 -> q=0;
   - minterms 9–11, 13, 14 -> q=1;
   - minterm 15 -> q=0.
5. WIDTH=4 instance: d=4'hA -> q=4'hA, qnot=4'h5. preset -> q=4'hF. Reset with RESET_VAL=4'h3 -> q=4'h3.
6. With DFF_CE_EN: ce=0, d toggles 0→1, preset=1 -> q holds its old value. rst_n=0 with ce=0 -> q=RESET_VAL. ce=1 -> q follows d on the next edge.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared definitions for the dff storage cell: default sizing and the
// next-state select encoding. Optional clock enable is DFF_CE_EN.
package dff_pkg;

  localparam int unsigned DFF_WIDTH_DEF     = 1;
  localparam logic        DFF_RESET_BIT_DEF = 1'b0;

  // Highest priority first; SEL_HOLD only arises when the clock enable is low.
  typedef enum logic [2:0] {
    SEL_RST,
    SEL_CLR,
    SEL_SET,
    SEL_D,
    SEL_HOLD
  } dff_sel_e;

  function automatic dff_sel_e dff_select(input logic rst_n,
                                          input logic clear,
                                          input logic preset,
                                          input logic ce);
    dff_sel_e sel;
    if (!rst_n)      sel = SEL_RST;
    else if (!ce)    sel = SEL_HOLD;
    else if (clear)  sel = SEL_CLR;
    else if (preset) sel = SEL_SET;
    else             sel = SEL_D;
    return sel;
  endfunction

endpackage

// File: rtl/dff_next.sv
// Combinational next-state mux for dff: reset > (enable) > clear > preset > d.
module dff_next
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT_DEF}}
) (
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_preset,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_next
);

  dff_sel_e w_sel;

  always_comb begin
    w_sel  = dff_select(i_rst_n, i_clear, i_preset, i_ce);
    o_next = i_q;
    unique case (w_sel)
      SEL_RST:  o_next = RESET_VAL;
      SEL_CLR:  o_next = '0;
      SEL_SET:  o_next = '1;
      SEL_D:    o_next = i_d;
      SEL_HOLD: o_next = i_q;
      default:  o_next = i_q;
    endcase
  end

endmodule

// File: rtl/dff.sv
// Positive-edge D flip-flop with complementary output, synchronous preset,
// clear and active-low reset. Define DFF_CE_EN to add the ce port.
module dff
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT_DEF}}
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  input  logic [WIDTH-1:0] d,
  input  logic             preset,
  input  logic             clear
`ifdef DFF_CE_EN
  ,
  input  logic             ce
`endif
);

  logic             w_ce;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_q;

`ifdef DFF_CE_EN
  assign w_ce = ce;
`else
  assign w_ce = 1'b1;
`endif

  dff_next #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_next (
    .i_rst_n  (rst_n),
    .i_clear  (clear),
    .i_preset (preset),
    .i_ce     (w_ce),
    .i_d      (d),
    .i_q      (r_q),
    .o_next   (w_next)
  );

  // Reset is also resolved in the mux; testing it here keeps it independent of ce.
  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= RESET_VAL;
    else        r_q <= w_next;
  end

  assign q    = r_q;
  assign qnot = ~r_q;

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: directed plan items plus randomized traffic
// against a rule-based reference model (1-bit and 4-bit instances).
module tb_dff;

  logic       clk;
  logic       rst_n;
  logic       preset;
  logic       clear;
  logic       ce;
  logic       d1;
  logic [3:0] d4;
  logic       q1, qn1;
  logic [3:0] q4, qn4;

  logic       m1;
  logic [3:0] m4;

  int unsigned n_chk;
  int unsigned n_pass;

  dff u_dff1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .q      (q1),
    .qnot   (qn1),
    .d      (d1),
    .preset (preset),
    .clear  (clear)
`ifdef DFF_CE_EN
    ,
    .ce     (ce)
`endif
  );

  dff #(
    .WIDTH     (4),
    .RESET_VAL (4'h3)
  ) u_dff4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .q      (q4),
    .qnot   (qn4),
    .d      (d4),
    .preset (preset),
    .clear  (clear)
`ifdef DFF_CE_EN
    ,
    .ce     (ce)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference rules: reset wins; a low enable freezes everything else;
  // clear beats preset; otherwise the flop copies d.
  function automatic logic [3:0] ref_q(input logic [3:0] cur, input logic [3:0] din,
                                       input logic [3:0] rv, input logic [3:0] ones,
                                       input logic r_n, input logic clr,
                                       input logic pre, input logic en);
    if (!r_n) return rv;
    if (!en)  return cur;
    if (clr)  return 4'h0;
    if (pre)  return ones;
    return din;
  endfunction

  task automatic step();
    logic       en;
    logic [3:0] t1;
    logic [3:0] n1;
`ifdef DFF_CE_EN
    en = ce;
`else
    en = 1'b1;
`endif
    @(posedge clk);
    t1 = ref_q({3'b0, m1}, {3'b0, d1}, 4'h0, 4'h1, rst_n, clear, preset, en);
    m1 = t1[0];
    m4 = ref_q(m4, d4, 4'h3, 4'hF, rst_n, clear, preset, en);
    #1;
    n1 = {3'b0, ~m1};
    check("q1", {3'b0, q1}, {3'b0, m1});
    check("qnot1", {3'b0, qn1}, n1);
    check("q4", q4, m4);
    check("qnot4", qn4, ~m4);
    @(negedge clk);
    check("q1_between_edges", {3'b0, q1}, {3'b0, m1});
    check("q4_between_edges", q4, m4);
  endtask

  initial begin
    logic [15:0] f_tbl;
    logic        a, b, c, dd;
    n_chk  = 0;
    n_pass = 0;
    m1     = 1'bx;
    m4     = 4'bx;
    f_tbl  = 16'h6E80;
    ce     = 1'b1;

    // 1: reset with d=1, then release
    rst_n = 1'b0; preset = 1'b0; clear = 1'b0; d1 = 1'b1; d4 = 4'hC;
    step();
    check("reset_q", {3'b0, q1}, 4'h0);
    check("reset_qnot", {3'b0, qn1}, 4'h1);
    check("reset_q4", q4, 4'h3);
    rst_n = 1'b1;
    step();
    check("release_q", {3'b0, q1}, 4'h1);

    // 2: capture pattern 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      d1 = i[0];
      d4 = 4'($urandom);
      step();
      check("capture", {3'b0, q1}, {3'b0, i[0]});
    end

    // 3: controls
    preset = 1'b1; d1 = 1'b0;
    step();
    check("preset", {3'b0, q1}, 4'h1);
    clear = 1'b1;
    step();
    check("clear_over_preset", {3'b0, q1}, 4'h0);
    check("clear_over_preset4", q4, 4'h0);
    clear = 1'b0; preset = 1'b0; d1 = 1'b1;
    step();
    check("back_to_d", {3'b0, q1}, 4'h1);
    rst_n = 1'b0; preset = 1'b1;
    step();
    check("reset_over_preset", {3'b0, q1}, 4'h0);
    rst_n = 1'b1; preset = 1'b0;

    // 4: registered boolean function over all minterms
    for (int m = 0; m < 16; m++) begin
      a = m[3]; b = m[2]; c = m[1]; dd = m[0];
      d1 = (~a & b & c & dd) | (a & ~c & dd) | (a & ~b & c) | (a & c & ~dd);
      d4 = 4'(m);
      step();
      check("minterm", {3'b0, q1}, {3'b0, f_tbl[m]});
    end

    // 5: 4-bit instance
    d4 = 4'hA;
    step();
    check("w4_d", q4, 4'hA);
    check("w4_qnot", qn4, 4'h5);
    preset = 1'b1;
    step();
    check("w4_preset", q4, 4'hF);
    preset = 1'b0; rst_n = 1'b0;
    step();
    check("w4_reset", q4, 4'h3);
    rst_n = 1'b1;

`ifdef DFF_CE_EN
    // 6: clock enable
    d1 = 1'b0; d4 = 4'h9;
    step();
    ce = 1'b0; d1 = 1'b1; d4 = 4'h6; preset = 1'b1;
    step();
    check("ce_hold", {3'b0, q1}, 4'h0);
    check("ce_hold4", q4, 4'h9);
    preset = 1'b0; rst_n = 1'b0;
    step();
    check("ce_reset", q4, 4'h3);
    rst_n = 1'b1; ce = 1'b1;
    step();
    check("ce_follow", q4, 4'h6);
`endif

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rst_n  = ($urandom_range(0, 15) != 0);
      preset = ($urandom_range(0, 3) == 0);
      clear  = ($urandom_range(0, 3) == 0);
`ifdef DFF_CE_EN
      ce     = ($urandom_range(0, 3) != 0);
`endif
      d1     = 1'($urandom);
      d4     = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
